// File: rtl/kamikaze_ahb_pkg.sv
// kamikaze_ahb_pkg: shared AHB encodings and bus-owner type for the IF/LS arbiter
package kamikaze_ahb_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [3:0] HPROT_INSN    = 4'b0000;
    localparam logic [3:0] HPROT_DATA    = 4'b0001;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} owner_e;
endpackage

// File: rtl/kamikaze_ahb_resp_latch.sv
// kamikaze_ahb_resp_latch: holds a finished data phase for a master whose next address is still blocked
module kamikaze_ahb_resp_latch (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        set_i,
    input  logic        clr_i,
    input  logic [31:0] rdata_i,
    input  logic        resp_i,
    output logic        pend_o,
    output logic [31:0] rdata_o,
    output logic        resp_o
);
    logic        pend_q;
    logic [31:0] rdata_q;
    logic        resp_q;

    // capture read data/error on set, keep it until the master is granted again
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pend_q  <= 1'b0;
            rdata_q <= '0;
            resp_q  <= 1'b0;
        end else if (set_i) begin
            pend_q  <= 1'b1;
            rdata_q <= rdata_i;
            resp_q  <= resp_i;
        end else if (clr_i) begin
            pend_q  <= 1'b0;
        end
    end

    assign pend_o  = pend_q;
    assign rdata_o = rdata_q;
    assign resp_o  = resp_q;
endmodule

// File: rtl/kamikaze_ahb_arbiter.sv
// kamikaze_ahb_arbiter: shares one AHB-Lite master port between instruction fetch and load/store
// Define KMKZ_ARB_STARVE_EN to let IF win after STARVE_MAX consecutive contended losses.
module kamikaze_ahb_arbiter
    import kamikaze_ahb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] if_haddr_i,
    input  logic [1:0]  if_htrans_i,
    output logic        if_hready_o,
    output logic [31:0] if_hrdata_o,
    output logic        if_hresp_o,
    input  logic [31:0] ls_haddr_i,
    input  logic [1:0]  ls_htrans_i,
    input  logic        ls_hwrite_i,
    input  logic [2:0]  ls_hsize_i,
    input  logic [31:0] ls_hwdata_i,
    output logic        ls_hready_o,
    output logic [31:0] ls_hrdata_o,
    output logic        ls_hresp_o,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic        HMASTLOCK,
    output logic [3:0]  HPROT,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);
    owner_e      addr_owner, addr_owner_q, data_owner_q;
    logic        req_if, req_ls, force_if, hold_q, last_ls_q, sel_ls;
    logic        pend_if, pend_ls, lat_resp_if, lat_resp_ls, unused_ok;
    logic [31:0] lat_rdata_if, lat_rdata_ls;

    assign req_if    = if_htrans_i[1];
    assign req_ls    = ls_htrans_i[1];
    assign unused_ok = ^{if_htrans_i[0], ls_htrans_i[0], STARVE_MAX != 0};

`ifdef KMKZ_ARB_STARVE_EN
    localparam int CW = $clog2(STARVE_MAX + 1);
    logic [CW-1:0] starve_q;

    assign force_if = req_if && starve_q == CW'(STARVE_MAX);

    // count contended IF losses (saturating); any IF grant starts the count over
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            starve_q <= '0;
        else if (HREADY && addr_owner == OWN_IF)
            starve_q <= '0;
        else if (HREADY && addr_owner == OWN_LS && req_if && req_ls && starve_q != CW'(STARVE_MAX))
            starve_q <= starve_q + 1'b1;
    end
`else
    assign force_if = 1'b0;
`endif

    // a wait-stated address stays with its owner; otherwise LS first unless IF is starved
    always_comb
        addr_owner = hold_q ? addr_owner_q : force_if ? OWN_IF : req_ls ? OWN_LS : req_if ? OWN_IF : OWN_NONE;

    // remember the presented owner, whether it stalled, and who owns the data phase
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hold_q       <= 1'b0;
            addr_owner_q <= OWN_NONE;
            data_owner_q <= OWN_NONE;
            last_ls_q    <= 1'b0;
        end else begin
            hold_q       <= !HREADY && addr_owner != OWN_NONE;
            addr_owner_q <= addr_owner;
            if (addr_owner != OWN_NONE)
                last_ls_q <= addr_owner == OWN_LS;
            if (HREADY)
                data_owner_q <= addr_owner;
        end
    end

    assign sel_ls    = addr_owner == OWN_LS || (addr_owner == OWN_NONE && last_ls_q);
    assign HADDR     = sel_ls ? ls_haddr_i : if_haddr_i;
    assign HTRANS    = (rst_i && addr_owner != OWN_NONE) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HWRITE    = sel_ls && ls_hwrite_i;
    assign HSIZE     = sel_ls ? ls_hsize_i : HSIZE_WORD;
    assign HPROT     = sel_ls ? HPROT_DATA : HPROT_INSN;
    assign HBURST    = 3'b000;
    assign HMASTLOCK = 1'b0;
    assign HWDATA    = data_owner_q == OWN_LS ? ls_hwdata_i : '0;

    assign if_hready_o = HREADY && (addr_owner == OWN_IF || (!req_if && !pend_if));
    assign ls_hready_o = HREADY && (addr_owner == OWN_LS || (!req_ls && !pend_ls));
    assign if_hrdata_o = pend_if ? lat_rdata_if : HRDATA;
    assign ls_hrdata_o = pend_ls ? lat_rdata_ls : HRDATA;
    assign if_hresp_o  = pend_if ? lat_resp_if : data_owner_q == OWN_IF && HRESP;
    assign ls_hresp_o  = pend_ls ? lat_resp_ls : data_owner_q == OWN_LS && HRESP;

    kamikaze_ahb_resp_latch u_lat_if (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .set_i   (HREADY && data_owner_q == OWN_IF && req_if && addr_owner != OWN_IF),
        .clr_i   (HREADY && addr_owner == OWN_IF),
        .rdata_i (HRDATA),
        .resp_i  (HRESP),
        .pend_o  (pend_if),
        .rdata_o (lat_rdata_if),
        .resp_o  (lat_resp_if)
    );

    kamikaze_ahb_resp_latch u_lat_ls (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .set_i   (HREADY && data_owner_q == OWN_LS && req_ls && addr_owner != OWN_LS),
        .clr_i   (HREADY && addr_owner == OWN_LS),
        .rdata_i (HRDATA),
        .resp_i  (HRESP),
        .pend_o  (pend_ls),
        .rdata_o (lat_rdata_ls),
        .resp_o  (lat_resp_ls)
    );
endmodule
